paddle_ctrl: RTL
================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter PADDLE_H, default 64, paddle height in lines; the position clamp limit is 480-PADDLE_H.
REQ-002 Parameter HYST, default 2, minimum change in mapped position before the pending position updates.
REQ-003 Parameter STALE_CYC, default 65535, number of clocks without a sample before STALE asserts.
REQ-004 CLOCK_50MHz  in  1  sole clock; all logic on rising edge.
REQ-005 RESET_n  in  1  reset, asynchronous assert, active-low.
REQ-006 BUSY  in  1  converter busy flag from the ADC interface stage; asynchronous to this logic.
REQ-007 DATA_AD0  in  8  channel-0 sample; stable while BUSY is low.
REQ-008 DATA_AD1  in  8  channel-1 sample; stable while BUSY is low.
REQ-009 FRAME_TICK  in  1  one-cycle pulse at vertical blank.
REQ-010 PADDLE0_Y  out  9  player-0 paddle top line, 0..480-PADDLE_H.
REQ-011 PADDLE1_Y  out  9  player-1 paddle top line, 0..480-PADDLE_H.
REQ-012 POS_VALID  out  1  one-cycle pulse when PADDLE0_Y/PADDLE1_Y are loaded.
REQ-013 STALE  out  1  high while no sample has arrived for STALE_CYC clocks.

Function
REQ-014 BUSY shall pass through a 2-flop synchronizer; a sample event is a synchronized 1->0 transition.
REQ-015 The FSM shall have the states IDLE, CAP, AVG, HYST, and shall return to IDLE after HYST (4 clocks per sample).
- IDLE: leave to CAP on a sample event.
- CAP: latch DATA_AD0/DATA_AD1 and shift them into the 4-deep history.
- AVG: compute avg = sum>>2 for each channel.
- HYST: map the average, compare it against the pending value, and write.
REQ-016 Each channel shall keep a 10-bit running sum, updated as sum + new - oldest; truncation shall not occur.
REQ-017 The first sample after reset shall preload all 4 history entries and set sum = 4*sample, so there is no ramp from zero.
REQ-018 Mapping shall be map = (avg*13)>>3, using a 12-bit intermediate, giving 0..414.
REQ-019 The clamped value shall be min(map, 480-PADDLE_H).
REQ-020 Pending shall be written only if |clamped - pending| >= HYST, or if this is the first sample after reset.
REQ-021 Sample events occurring in CAP, AVG or HYST shall be ignored; the next event shall be taken normally.
REQ-022 On FRAME_TICK, outputs shall load from pending and POS_VALID shall pulse high 1 cycle later, coincident with the new outputs.
- A FRAME_TICK in the same cycle as a pending write uses the old pending value.
- Before the first sample, FRAME_TICK still loads (pending holds its reset value) and POS_VALID still pulses.
REQ-023 The stale counter shall clear on each sample event, saturate at STALE_CYC, and drive STALE = (count == STALE_CYC).
REQ-024 While STALE is high, outputs shall hold their last values; STALE shall deassert on the cycle after the next sample event.

Reset
REQ-025 On RESET_n low, every register shall clear immediately, without waiting for a clock edge.
REQ-026 Reset values:
- FSM = IDLE.
- Synchronizer flops = 1.
- History, sums and stale counter = 0.
- First-sample flag = 1.
- Pending = (480-PADDLE_H)/2 (208 with the default PADDLE_H).
- PADDLE0_Y = PADDLE1_Y = (480-PADDLE_H)/2.
- POS_VALID = 0, STALE = 0.
REQ-027 Reset asserted mid-FSM shall discard the in-flight sample; the first event after release is again treated as a first sample.

Verification
REQ-028 Reset, then BUSY falls with DATA_AD0=0x80 and DATA_AD1=0xFF, then FRAME_TICK -> PADDLE0_Y=208, PADDLE1_Y=414, and POS_VALID pulses once.
REQ-029 PADDLE_H=100, DATA_AD1=0xFF, then FRAME_TICK -> PADDLE1_Y=380 (clamped).
REQ-030 After settling at 0x80, apply one sample of 0x84 -> avg=129 and map=209 (delta 1 < HYST), so PADDLE0_Y stays 208; four samples of 0x84 -> avg=132, map=214, PADDLE0_Y=214 at the next tick.
REQ-031 FRAME_TICK asserted in the same cycle as the HYST write -> outputs keep the old value, and the new value appears at the following tick.
REQ-032 No BUSY edges for STALE_CYC clocks -> STALE=1 and outputs held; one sample -> STALE=0.
REQ-033 RESET_n pulsed low while in AVG -> outputs=208 and FSM=IDLE asynchronously; the next sample preloads the history (no averaging with pre-reset data).

Source files
------------

// File: rtl/paddle_ctrl.sv
// Paddle position controller: samples two ADC channels on each synchronized BUSY
// falling edge, averages four samples, maps to screen lines and publishes on FRAME_TICK.
module paddle_ctrl #(
    parameter int PADDLE_H  = 64,
    parameter int HYST      = 2,
    parameter int STALE_CYC = 65535
) (
    input  logic       CLOCK_50MHz,
    input  logic       RESET_n,
    input  logic       BUSY,
    input  logic [7:0] DATA_AD0,
    input  logic [7:0] DATA_AD1,
    input  logic       FRAME_TICK,
    output logic [8:0] PADDLE0_Y,
    output logic [8:0] PADDLE1_Y,
    output logic       POS_VALID,
    output logic       STALE
);

    localparam logic [8:0] Y_MAX   = 9'(480 - PADDLE_H);
    localparam logic [8:0] Y_RST   = 9'((480 - PADDLE_H) / 2);
    localparam int         CNT_W   = $clog2(STALE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALE_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAP,
        S_AVG,
        S_HYST
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             busy_sync_q, busy_sync_d;
    logic                   busy_prev_q, busy_prev_d;
    logic                   first_q, first_d;
    logic [1:0][3:0][7:0]   hist_q, hist_d;
    logic [1:0][9:0]        sum_q, sum_d;
    logic [1:0][7:0]        avg_q, avg_d;
    logic [1:0][8:0]        pend_q, pend_d;
    logic [1:0][8:0]        y_q, y_d;
    logic                   valid_q, valid_d;
    logic [CNT_W-1:0]       stale_cnt_q, stale_cnt_d;

    logic                   sample_ev;
    logic                   stale_now;
    logic [1:0][7:0]        data_in;

    function automatic logic [8:0] map_clamp(input logic [7:0] avg);
        logic [11:0] prod;
        logic [8:0]  mapped;
        prod   = {4'b0, avg} * 12'd13;
        mapped = prod[11:3];
        return (mapped > Y_MAX) ? Y_MAX : mapped;
    endfunction

    function automatic logic [8:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign data_in   = {DATA_AD1, DATA_AD0};
    assign sample_ev = busy_prev_q & ~busy_sync_q[1];
    assign stale_now = (stale_cnt_q == CNT_MAX);

    always_comb begin
        state_d     = state_q;
        busy_sync_d = {busy_sync_q[0], BUSY};
        busy_prev_d = busy_sync_q[1];
        first_d     = first_q;
        hist_d      = hist_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        pend_d      = pend_q;
        y_d         = y_q;
        valid_d     = 1'b0;
        stale_cnt_d = stale_cnt_q;

        unique case (state_q)
            S_IDLE: if (sample_ev) state_d = S_CAP;
            S_CAP: begin
                for (int ch = 0; ch < 2; ch++) begin
                    // First sample fills the whole window so the average starts at the real value.
                    if (first_q) begin
                        hist_d[ch] = {4{data_in[ch]}};
                        sum_d[ch]  = {data_in[ch], 2'b00};
                    end else begin
                        hist_d[ch] = {hist_q[ch][2:0], data_in[ch]};
                        sum_d[ch]  = sum_q[ch] - 10'(hist_q[ch][3]) + 10'(data_in[ch]);
                    end
                end
                state_d = S_AVG;
            end
            S_AVG: begin
                for (int ch = 0; ch < 2; ch++) avg_d[ch] = sum_q[ch][9:2];
                state_d = S_HYST;
            end
            S_HYST: begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (first_q || (abs_diff(map_clamp(avg_q[ch]), pend_q[ch]) >= 9'(HYST)))
                        pend_d[ch] = map_clamp(avg_q[ch]);
                end
                first_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs freeze while the ADC is silent.
        if (FRAME_TICK && !stale_now) begin
            y_d     = pend_q;
            valid_d = 1'b1;
        end

        if (sample_ev)
            stale_cnt_d = '0;
        else if (!stale_now)
            stale_cnt_d = stale_cnt_q + 1'b1;
    end

    // NOTE: state uses non-blocking assignments only; the history window is cleared on
    // reset because an in-flight sample must never leak across a reset.
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= S_IDLE;
            busy_sync_q <= 2'b11;
            busy_prev_q <= 1'b1;
            first_q     <= 1'b1;
            hist_q      <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            pend_q      <= {Y_RST, Y_RST};
            y_q         <= {Y_RST, Y_RST};
            valid_q     <= 1'b0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_sync_q <= busy_sync_d;
            busy_prev_q <= busy_prev_d;
            first_q     <= first_d;
            hist_q      <= hist_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            pend_q      <= pend_d;
            y_q         <= y_d;
            valid_q     <= valid_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign PADDLE0_Y = y_q[0];
    assign PADDLE1_Y = y_q[1];
    assign POS_VALID = valid_q;
    assign STALE     = stale_now;

endmodule
